// File: rtl/etm_mult_pipe.sv
// Two-stage pipelined Error Tolerant Multiplier with a runtime split K and a valid/ready stream.
// Define ETM_ERRSTAT_EN to add the exact reference multiplier and the saturating error/op counters.
module etm_mult_pipe #(
  parameter int N     = 16,
  parameter int TAG_W = 4,
  parameter int CNT_W = 32,
  localparam int KW   = $clog2(N+1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     a_i,
  input  logic [N-1:0]     b_i,
  input  logic [KW-1:0]    split_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [2*N-1:0]   p_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] op_cnt_o
);

  logic             en;
  logic [KW-1:0]    k_in;

  logic             s1_valid;
  logic [N-1:0]     s1_a;
  logic [N-1:0]     s1_b;
  logic [KW-1:0]    s1_k;
  logic [TAG_W-1:0] s1_tag;

  logic [N-1:0]     lo_mask;
  logic [N-1:0]     a_hi;
  logic [N-1:0]     b_hi;
  logic [N-1:0]     lo_or;
  logic [N-1:0]     sor;
  logic             sor_acc;
  logic             exact_mode;
  logic [N-1:0]     mul_a;
  logic [N-1:0]     mul_b;
  logic [KW:0]      k2;
  logic [2*N-1:0]   prod;
  logic [2*N-1:0]   t_field;
  logic [2*N-1:0]   p_next;

  // The whole pipe freezes while a result waits; bubbles are kept, not squeezed.
  assign en         = ~out_valid_o | out_ready_i;
  assign in_ready_o = en;
  assign k_in       = (split_i >= KW'(N)) ? KW'(N) : split_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_k     <= '0;
      s1_tag   <= '0;
    end else if (en) begin
      s1_valid <= in_valid_i;
      s1_a     <= a_i;
      s1_b     <= b_i;
      s1_k     <= k_in;
      s1_tag   <= tag_i;
    end
  end

  // Split operands with masks so K can change every beat without per-K hardware.
  always_comb begin
    lo_mask    = ~({N{1'b1}} << s1_k);
    a_hi       = s1_a >> s1_k;
    b_hi       = s1_b >> s1_k;
    lo_or      = (s1_a | s1_b) & lo_mask;
    exact_mode = (s1_k == '0) || (s1_k == KW'(N)) || ((a_hi == '0) && (b_hi == '0));
    mul_a      = exact_mode ? s1_a : a_hi;
    mul_b      = exact_mode ? s1_b : b_hi;
    k2         = {s1_k, 1'b0};
  end

  // sor[i] is set when any low-part OR bit at position >= i is set (priority-OR from the top).
  always_comb begin
    sor     = '0;
    sor_acc = 1'b0;
    for (int i = N-1; i >= 0; i--) begin
      sor_acc = sor_acc | lo_or[i];
      sor[i]  = sor_acc;
    end
  end

  // One multiplier serves both modes: full operands when exact, upper parts otherwise.
  always_comb begin
    prod    = {{N{1'b0}}, mul_a} * {{N{1'b0}}, mul_b};
    t_field = ({{N{1'b0}}, sor} << s1_k) | (sor[0] ? {{N{1'b0}}, lo_mask} : '0);
    p_next  = exact_mode ? prod : ((prod << k2) | t_field);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      p_o         <= '0;
      tag_o       <= '0;
    end else if (en) begin
      out_valid_o <= s1_valid;
      p_o         <= p_next;
      tag_o       <= s1_tag;
    end
  end

`ifdef ETM_ERRSTAT_EN
  logic [2*N-1:0]   exact_p;
  logic             s2_err;
  logic             deliver;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] op_cnt;

  assign exact_p = {{N{1'b0}}, s1_a} * {{N{1'b0}}, s1_b};
  assign deliver = out_valid_o & out_ready_i;

  // The mismatch flag rides alongside p_o so it is counted exactly when the result leaves.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_err <= 1'b0;
    end else if (en) begin
      s2_err <= (p_next != exact_p);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_cnt  <= '0;
      err_cnt <= '0;
    end else if (clear_i) begin
      op_cnt  <= '0;
      err_cnt <= '0;
    end else if (deliver) begin
      if (op_cnt != {CNT_W{1'b1}}) begin
        op_cnt <= op_cnt + 1'b1;
      end
      if (s2_err && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign err_cnt_o = err_cnt;
  assign op_cnt_o  = op_cnt;
`else
  logic unused_clear;

  assign unused_clear = clear_i;
  assign err_cnt_o    = '0;
  assign op_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_etm_mult_pipe.sv
// Self-checking bench for etm_mult_pipe (N=8): directed table, hand sequences, random traffic
// against an arithmetic reference model; counter expectations follow ETM_ERRSTAT_EN.
module tb_etm_mult_pipe;
  localparam int N     = 8;
  localparam int TAG_W = 4;
  localparam int CNT_W = 32;
  localparam int KW    = $clog2(N+1);

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [KW-1:0]    split;
  logic [TAG_W-1:0] tag_in;
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   p;
  logic [TAG_W-1:0] tag_out;
  logic             out_valid;
  logic             out_ready;
  logic             clear;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] op_cnt;

  etm_mult_pipe #(.N(N), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .a_i(a), .b_i(b), .split_i(split), .tag_i(tag_in),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .p_o(p), .tag_o(tag_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .clear_i(clear),
    .err_cnt_o(err_cnt), .op_cnt_o(op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p;
    logic [3:0]  tag;
    logic [15:0] ex;
  } exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  k;
    logic [15:0] p;
  } vec_t;

  exp_t sbq[$];
  int   checks;
  int   errors;
  int   exp_ops;
  int   exp_errs;
  bit   last_accept;

  // Reference ETM computed straight from the arithmetic definition.
  function automatic logic [15:0] etm_ref(logic [7:0] ra, logic [7:0] rb, logic [3:0] rs);
    int k, ah, bh, al, bl, orv;
    logic [15:0] t;
    k = (int'(rs) >= N) ? N : int'(rs);
    if (k == 0 || k == N) return 16'(int'(ra) * int'(rb));
    ah = int'(ra) >> k;
    bh = int'(rb) >> k;
    al = int'(ra) % (1 << k);
    bl = int'(rb) % (1 << k);
    if (ah == 0 && bh == 0) return 16'(al * bl);
    orv = al | bl;
    t = '0;
    for (int j = 0; j < k; j++) t[2*k-1-j] = ((orv >> (k-1-j)) != 0);
    for (int i = 0; i < k; i++) t[i] = t[k];
    return 16'((ah * bh) << (2*k)) | t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle from a negedge; scoreboards delivery and acceptance at the coming posedge.
  task automatic applyStimulus(input bit v, input logic [7:0] sa, input logic [7:0] sb,
                               input logic [3:0] sk, input logic [3:0] st, input bit ordy,
                               input bit clr, input bit use_exp, input logic [15:0] pexp);
    exp_t e;
    in_valid  = v;
    a         = sa;
    b         = sb;
    split     = sk;
    tag_in    = st;
    out_ready = ordy;
    clear     = clr;
    #1;
    checkOutput("op_cnt", op_cnt, 32'(exp_ops));
    checkOutput("err_cnt", err_cnt, 32'(exp_errs));
    if (out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got p=0x%0h, expected no result", p);
      end else begin
        checkOutput("p_o", 32'(p), 32'(sbq[0].p));
        checkOutput("tag_o", 32'(tag_out), 32'(sbq[0].tag));
        if (ordy) begin
          e = sbq.pop_front();
`ifdef ETM_ERRSTAT_EN
          exp_ops++;
          if (e.p != e.ex) exp_errs++;
`endif
        end
      end
    end
    if (clr) begin
      exp_ops  = 0;
      exp_errs = 0;
    end
    last_accept = v && in_ready;
    if (last_accept) begin
      e.p   = use_exp ? pexp : etm_ref(sa, sb, sk);
      e.tag = st;
      e.ex  = 16'(int'(sa) * int'(sb));
      sbq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    applyStimulus(1'b0, 8'h0, 8'h0, 4'h0, 4'h0, ordy, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sbq.size() > 0; i++) idle(1'b1);
    checkOutput("drained", 32'(sbq.size()), 32'd0);
  endtask

  vec_t tbl[8];
  int   idx;
  logic [7:0] bp_a[3];
  logic [7:0] bp_b[3];
  logic [3:0] bp_k[3];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0; errors = 0; exp_ops = 0; exp_errs = 0;
    rst_n = 1'b0; in_valid = 0; a = 0; b = 0; split = 0; tag_in = 0; out_ready = 0; clear = 0;

    tbl[0] = '{8'h35, 8'h21, 4'd4, 16'h067F};
    tbl[1] = '{8'h35, 8'h21, 4'd0, 16'h06D5};
    tbl[2] = '{8'h35, 8'h21, 4'd9, 16'h06D5};
    tbl[3] = '{8'hFF, 8'hFF, 4'd8, 16'hFE01};
    tbl[4] = '{8'h80, 8'h01, 4'd4, 16'h001F};
    tbl[5] = '{8'h12, 8'h34, 4'd2, 16'h034F};
    tbl[6] = '{8'h0F, 8'h80, 4'd7, 16'h07FF};
    tbl[7] = '{8'h0B, 8'h07, 4'd15, 16'h004D};

    @(negedge clk);
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst p_o", 32'(p), 32'd0);
    checkOutput("rst tag_o", 32'(tag_out), 32'd0);
    checkOutput("rst in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Case 1: low-only operands, exact product, 2-cycle latency.
    applyStimulus(1'b1, 8'h0B, 8'h07, 4'd4, 4'h5, 1'b1, 1'b0, 1'b1, 16'h004D);
    checkOutput("lat1 out_valid", 32'(out_valid), 32'd0);
    idle(1'b1);
    checkOutput("lat2 out_valid", 32'(out_valid), 32'd1);
    drain();

    // Case 2 then statistics and clear.
    applyStimulus(1'b1, 8'h35, 8'h21, 4'd4, 4'h6, 1'b1, 1'b0, 1'b1, 16'h067F);
    drain();
`ifdef ETM_ERRSTAT_EN
    checkOutput("stat op_cnt", op_cnt, 32'd2);
    checkOutput("stat err_cnt", err_cnt, 32'd1);
`else
    checkOutput("stat op_cnt", op_cnt, 32'd0);
    checkOutput("stat err_cnt", err_cnt, 32'd0);
`endif
    applyStimulus(1'b0, 8'h0, 8'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 16'h0);
    checkOutput("clr op_cnt", op_cnt, 32'd0);
    checkOutput("clr err_cnt", err_cnt, 32'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, tbl[i].a, tbl[i].b, tbl[i].k, 4'(i), 1'b1, 1'b0, 1'b1, tbl[i].p);
      drain();
    end

    // Back-to-back K=4,0,4 at full throughput.
    applyStimulus(1'b1, 8'h35, 8'h21, 4'd4, 4'h1, 1'b1, 1'b0, 1'b1, 16'h067F);
    applyStimulus(1'b1, 8'h35, 8'h21, 4'd0, 4'h2, 1'b1, 1'b0, 1'b1, 16'h06D5);
    applyStimulus(1'b1, 8'h35, 8'h21, 4'd4, 4'h3, 1'b1, 1'b0, 1'b1, 16'h067F);
    drain();

    // Back-pressure: out_ready low for 5 cycles while 3 ops are offered.
    bp_a = '{8'h35, 8'h0B, 8'hC3};
    bp_b = '{8'h21, 8'h07, 8'h5A};
    bp_k = '{4'd4, 4'd3, 4'd5};
    idx = 0;
    for (int cyc = 0; cyc < 40 && (idx < 3 || sbq.size() > 0); cyc++) begin
      if (idx < 3) applyStimulus(1'b1, bp_a[idx], bp_b[idx], bp_k[idx], 4'(8 + idx), cyc >= 5, 1'b0, 1'b0, 16'h0);
      else idle(1'b1);
      if (last_accept) idx++;
      if (cyc == 3) begin
        checkOutput("bp in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp out_valid", 32'(out_valid), 32'd1);
        checkOutput("bp accepted", 32'(idx), 32'd2);
      end
    end
    checkOutput("bp all accepted", 32'(idx), 32'd3);
    checkOutput("bp drained", 32'(sbq.size()), 32'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom % 4) != 0, 8'($urandom), 8'($urandom), 4'($urandom % 16),
                    4'($urandom), ($urandom % 3) != 0, ($urandom % 60) == 0, 1'b0, 16'h0);
    end
    drain();

    // Reset while a result is waiting.
    applyStimulus(1'b1, 8'h35, 8'h21, 4'd4, 4'h7, 1'b0, 1'b0, 1'b0, 16'h0);
    idle(1'b0);
    checkOutput("pre-rst out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst mid out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst mid op_cnt", op_cnt, 32'd0);
    checkOutput("rst mid err_cnt", err_cnt, 32'd0);
    sbq.delete();
    exp_ops  = 0;
    exp_errs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    #1;
    checkOutput("post-rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b1, 8'h35, 8'h21, 4'd4, 4'h9, 1'b1, 1'b0, 1'b1, 16'h067F);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
